// File: rtl/sdc_seq_pkg.sv
// sdc_seq_pkg: shared types and register map for the SD command sequencer
package sdc_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_ARG,
        S_WR_CMD,
        S_POLL,
        S_CLR,
        S_RD_RSP,
        S_DONE
    } state_t;

    localparam logic [6:0] ARG_BASE_DEF = 7'h00;
    localparam logic [6:0] CMD_BASE_DEF = 7'h04;
    localparam logic [6:0] STS_ADDR_DEF = 7'h38;
    localparam logic [6:0] RSP_BASE_DEF = 7'h44;
    localparam int         TIMEOUT_DEF  = 1024;

    localparam int         STS_CMPL = 0;
    localparam int         STS_ERR  = 1;
    localparam logic [7:0] STS_MASK = 8'h03;

    function automatic logic is_xfer(state_t s);
        return s inside {S_WR_ARG, S_WR_CMD, S_POLL, S_CLR, S_RD_RSP};
    endfunction
endpackage

// File: rtl/sdc_reg_port.sv
// sdc_reg_port: two-cycle byte read/write engine driving the sdc_controller register port
module sdc_reg_port (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rnw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic       o_done,
    output logic       o_idle,
    output logic [7:0] o_rdata,
    output logic [6:0] o_bus_addr,
    output logic [7:0] o_bus_wdata,
    output logic       o_bus_we,
    input  logic [7:0] i_bus_rdata
);
    logic       r_a;
    logic       r_b;
    logic       r_rnw;
    logic       r_we;
    logic [6:0] r_addr;
    logic [7:0] r_wdata;

    // r_a marks cycle A, r_b cycle B; a new start may land on the edge that ends B
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_rnw   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_a  <= i_start;
            r_b  <= r_a;
            r_we <= r_a && !r_rnw;
            if (i_start) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_rnw   <= i_rnw;
            end
        end
    end

    assign o_done      = r_b;
    assign o_idle      = !r_a && !r_b;
    assign o_rdata     = i_bus_rdata;
    assign o_bus_addr  = r_addr;
    assign o_bus_wdata = r_wdata;
    assign o_bus_we    = r_we;
endmodule

// File: rtl/sdc_cmd_sequencer.sv
// sdc_cmd_sequencer: writes one SD command into sdc_controller, polls status,
// clears it and returns the 32-bit response
module sdc_cmd_sequencer
    import sdc_seq_pkg::*;
#(
    parameter logic [6:0] ARG_BASE = ARG_BASE_DEF,
    parameter logic [6:0] CMD_BASE = CMD_BASE_DEF,
    parameter logic [6:0] STS_ADDR = STS_ADDR_DEF,
    parameter logic [6:0] RSP_BASE = RSP_BASE_DEF,
    parameter int         TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [15:0] i_req_cmd,
    input  logic [31:0] i_req_arg,
    output logic [6:0]  o_addr,
    output logic [7:0]  o_wdata,
    input  logic [7:0]  i_rdata,
    output logic        o_we,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err,
    output logic        o_busy
);
    localparam int PW = $clog2(TIMEOUT + 1);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_idx, w_idx_nxt;
    logic [PW-1:0] r_polls, w_polls_nxt;
    logic [15:0]   r_cmd, w_cmd_nxt;
    logic [31:0]   r_arg, w_arg_nxt;
    logic [31:0]   r_rsp_data, w_rsp_data_nxt;
    logic          r_err, w_err_nxt;
    logic          r_req_ready;
    logic          r_rsp_valid;
    logic          r_busy;
    logic          w_done;
    logic          w_idle;
    logic          w_start;
    logic          w_rnw;
    logic [6:0]    w_addr;
    logic [7:0]    w_wdata;
    logic [7:0]    w_rdata;

    sdc_reg_port u_port (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (w_start),
        .i_rnw       (w_rnw),
        .i_addr      (w_addr),
        .i_wdata     (w_wdata),
        .o_done      (w_done),
        .o_idle      (w_idle),
        .o_rdata     (w_rdata),
        .o_bus_addr  (o_addr),
        .o_bus_wdata (o_wdata),
        .o_bus_we    (o_we),
        .i_bus_rdata (i_rdata)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_polls     <= '0;
            r_cmd       <= '0;
            r_arg       <= '0;
            r_rsp_data  <= '0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_polls     <= w_polls_nxt;
            r_cmd       <= w_cmd_nxt;
            r_arg       <= w_arg_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_err       <= w_err_nxt;
            r_req_ready <= w_state_nxt == S_IDLE;
            r_rsp_valid <= w_state_nxt == S_DONE;
            r_busy      <= w_state_nxt != S_IDLE;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_polls_nxt    = r_polls;
        w_cmd_nxt      = r_cmd;
        w_arg_nxt      = r_arg;
        w_rsp_data_nxt = r_rsp_data;
        w_err_nxt      = r_err;
        case (r_state)
            S_IDLE: if (i_req_valid && r_req_ready) begin
                w_cmd_nxt      = i_req_cmd;
                w_arg_nxt      = i_req_arg;
                w_idx_nxt      = '0;
                w_rsp_data_nxt = '0;
                w_err_nxt      = 1'b0;
                w_state_nxt    = S_WR_ARG;
            end
            S_WR_ARG: if (w_done) begin
                w_idx_nxt   = r_idx + 2'd1;
                w_state_nxt = r_idx == 2'd3 ? S_WR_CMD : S_WR_ARG;
            end
            S_WR_CMD: if (w_done) begin
                w_idx_nxt   = r_idx == 2'd1 ? 2'd0 : r_idx + 2'd1;
                w_polls_nxt = '0;
                w_state_nxt = r_idx == 2'd1 ? S_POLL : S_WR_CMD;
            end
            S_POLL: if (w_done) begin
                w_polls_nxt = r_polls + 1'b1;
                if (w_rdata[STS_ERR]) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_CLR;
                end else if (w_rdata[STS_CMPL]) begin
                    w_state_nxt = S_CLR;
                end else if (w_polls_nxt == PW'(TIMEOUT)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_CLR: if (w_done) w_state_nxt = r_err ? S_DONE : S_RD_RSP;
            S_RD_RSP: if (w_done) begin
                w_rsp_data_nxt[8*r_idx +: 8] = w_rdata;
                w_idx_nxt   = r_idx + 2'd1;
                w_state_nxt = r_idx == 2'd3 ? S_DONE : S_RD_RSP;
            end
            S_DONE: if (i_rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // next access is launched on the edge that ends the current one, so bytes run back to back
        w_start = is_xfer(r_state) && is_xfer(w_state_nxt) && (w_done || w_idle);
        w_rnw   = w_state_nxt inside {S_POLL, S_RD_RSP};
        w_addr  = w_state_nxt == S_WR_ARG ? ARG_BASE + 7'(w_idx_nxt) :
                  w_state_nxt == S_WR_CMD ? CMD_BASE + 7'(w_idx_nxt) :
                  w_state_nxt == S_RD_RSP ? RSP_BASE + 7'(w_idx_nxt) : STS_ADDR;
        w_wdata = w_state_nxt == S_WR_ARG ? r_arg[8*w_idx_nxt +: 8] :
                  w_state_nxt == S_WR_CMD ? r_cmd[8*w_idx_nxt[0] +: 8] :
                  w_state_nxt == S_CLR    ? w_rdata & STS_MASK : 8'h00;
    end

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_rsp_err   = r_err;
    assign o_busy      = r_busy;
endmodule

// File: tb/tb_sdc_cmd_sequencer.sv
// tb_sdc_cmd_sequencer: randomized scoreboard bench with a register-port slave model
module tb_sdc_cmd_sequencer;
    localparam int TMO  = 4;
    localparam int K_OK = 0;
    localparam int K_ER = 1;
    localparam int K_TO = 2;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          lat;
        int          acc;
        int          rd;
        int          st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_cmd = '0;
    logic [31:0] req_arg = '0;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        we;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    exp_t        sq[$];
    logic [14:0] wq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_done = 0;
    int          hold = 0;
    int          s_n = 1;
    int          since = 0;
    logic        launched = 1'b0;
    logic [7:0]  s_sts = '0;
    logic [7:0]  s_pre = '0;
    logic [7:0]  s_rsp [4];

    always #5 clk = ~clk;

    sdc_cmd_sequencer #(.TIMEOUT(TMO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_cmd   (req_cmd),
        .i_req_arg   (req_arg),
        .o_addr      (addr),
        .o_wdata     (wdata),
        .i_rdata     (rdata),
        .o_we        (we),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_data  (rsp_data),
        .o_rsp_err   (rsp_err),
        .o_busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // slave: status turns to s_sts from the s_n-th poll after the launch write to 0x05
    always @(posedge clk) begin
        if (req_valid && req_ready) launched <= 1'b0;
        else if (we && addr == 7'h05) begin
            launched <= 1'b1;
            since    <= 0;
        end else since <= since + 1;
    end

    always_comb begin
        rdata = 8'h00;
        if (addr == 7'h38) rdata = (launched && since >= 2 * s_n - 1) ? s_sts : s_pre;
        else if (addr >= 7'h44 && addr <= 7'h47) rdata = s_rsp[addr[1:0]];
    end

    logic pwe = 1'b0;
    always @(negedge clk) begin
        if (we) begin
            chk("we_single_cycle", {31'b0, pwe}, 0);
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %h<-%h expected none", addr, wdata);
            end else begin
                logic [14:0] w;
                w = wq.pop_front();
                chk("wr_addr", {25'b0, addr}, {25'b0, w[14:8]});
                chk("wr_data", {24'b0, wdata}, {24'b0, w[7:0]});
            end
        end
        pwe = we;
    end

    logic pv = 1'b0;
    logic pbusy = 1'b0;
    int   rd_cyc = 0;
    int   st_cyc = 0;
    int   wait_cnt = 0;
    exp_t cur = '{default: 0};
    always @(negedge clk) begin
        if (rst) begin
            rsp_ready = 1'b0;
            pv        = 1'b0;
            rd_cyc    = 0;
            st_cyc    = 0;
        end else begin
            if (busy && pbusy && !rsp_valid) begin
                if (addr >= 7'h44 && addr <= 7'h47) rd_cyc++;
                if (addr == 7'h38 && !we) st_cyc++;
            end
            if (rsp_valid) begin
                if (!pv) begin
                    if (sq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got %h expected none", rsp_data);
                        cur = '{default: 0};
                    end else begin
                        cur = sq.pop_front();
                        chk("latency", cyc - cur.acc, cur.lat);
                        chk("rsp_read_cycles", rd_cyc, cur.rd);
                        chk("sts_read_cycles", st_cyc, cur.st);
                        chk("writes_drained", wq.size(), 0);
                    end
                    rd_cyc   = 0;
                    st_cyc   = 0;
                    wait_cnt = hold;
                end
                chk("rsp_data", rsp_data, cur.d);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.e});
                chk("req_ready_in_done", {31'b0, req_ready}, 0);
                if (wait_cnt == 0) begin
                    rsp_ready = 1'b1;
                    n_done++;
                end else begin
                    wait_cnt--;
                    rsp_ready = 1'b0;
                end
            end else rsp_ready = 1'b0;
            pv = rsp_valid;
        end
        pbusy = busy;
    end

    task automatic do_reset_checks();
        chk("rst_we", {31'b0, we}, 0);
        chk("rst_addr", {25'b0, addr}, 0);
        chk("rst_wdata", {24'b0, wdata}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_req_ready", {31'b0, req_ready}, 0);
    endtask

    task automatic txn(input int kind, input int n, input logic [7:0] sts, input logic [7:0] pre,
                       input logic [15:0] cmd, input logic [31:0] arg, input logic [31:0] rsp,
                       input int h, input bit bp, input bit rmid);
        exp_t e;
        int   k;
        int   polls;
        int   base;
        s_n   = kind == K_TO ? 100000 : n;
        s_sts = sts;
        s_pre = pre;
        for (int i = 0; i < 4; i++) s_rsp[i] = rsp[8*i +: 8];
        hold = h;
        for (int i = 0; i < 4; i++) wq.push_back({7'(i), arg[8*i +: 8]});
        for (int i = 0; i < 2; i++) wq.push_back({7'(4 + i), cmd[8*i +: 8]});
        if (kind != K_TO) wq.push_back({7'h38, sts & 8'h03});
        polls = kind == K_TO ? TMO : n;
        e.d   = kind == K_OK ? rsp : 32'h0;
        e.e   = kind != K_OK;
        e.lat = 1 + 12 + 2 * polls + (kind == K_TO ? 0 : (kind == K_OK ? 10 : 2));
        e.rd  = kind == K_OK ? 8 : 0;
        e.st  = kind == K_TO ? 2 * TMO : 2 * n + 1;
        req_cmd   = cmd;
        req_arg   = arg;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 1, 0);
            req_valid = 1'b0;
            wq.delete();
            return;
        end
        e.acc = cyc + 1;
        sq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        if (rmid) begin
            k = 0;
            while (!(we && addr == 7'h04) && k < 40) begin
                @(negedge clk);
                k++;
            end
            chk("reach_byte5", {31'b0, we}, 1);
            rst = 1'b1;
            #1;
            do_reset_checks();
            wq.delete();
            sq.delete();
            @(negedge clk);
            chk("rst_hold_req_ready", {31'b0, req_ready}, 0);
            rst = 1'b0;
            @(negedge clk);
            chk("post_rst_req_ready", {31'b0, req_ready}, 1);
            return;
        end
        if (bp) begin
            k = 0;
            while (!rsp_valid && k < 100) begin
                @(negedge clk);
                k++;
            end
            req_cmd   = ~cmd;
            req_valid = 1'b1;
            @(negedge clk);
            req_valid = 1'b0;
            chk("bp_req_ready", {31'b0, req_ready}, 0);
        end
        base = n_done;
        k = 0;
        while (n_done == base && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_seen", {31'b0, n_done != base}, 1);
        k = 0;
        while (!req_ready && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("back_to_idle", {31'b0, req_ready}, 1);
        chk("idle_busy", {31'b0, busy}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int kind;
        logic [7:0] sts;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        do_reset_checks();
        rst = 1'b0;
        @(negedge clk);
        chk("first_req_ready", {31'b0, req_ready}, 1);
        txn(K_OK, 3, 8'h01, 8'h00, 16'h0811, 32'h000001AA, 32'h000001AA, 0, 0, 0);
        txn(K_ER, 1, 8'h03, 8'h00, 16'h0811, 32'h000001AA, 32'h12345678, 0, 0, 0);
        txn(K_TO, 1, 8'h00, 8'h00, 16'h0811, 32'h000001AA, 32'h12345678, 0, 0, 0);
        txn(K_OK, 1, 8'hF1, 8'h00, 16'h1234, 32'hDEADBEEF, 32'hCAFEF00D, 10, 1, 0);
        txn(K_OK, 2, 8'h01, 8'h00, 16'h0811, 32'h000001AA, 32'h000001AA, 0, 0, 1);
        txn(K_OK, 1, 8'h01, 8'h00, 16'h0811, 32'h000001AA, 32'h89ABCDEF, 0, 0, 0);
        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            sts  = 8'($urandom) & 8'hFC;
            sts  = kind == K_OK ? sts | 8'h01 : sts | 8'h02 | 8'($urandom_range(0, 1));
            txn(kind, $urandom_range(1, TMO), sts, 8'($urandom) & 8'hFC, 16'($urandom),
                $urandom, $urandom, $urandom_range(0, 3), 0, 0);
        end
        repeat (3) @(negedge clk);
        chk("final_wq_empty", wq.size(), 0);
        chk("final_sq_empty", sq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
